mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 512: number of 32-bit words; legal range 2..512.
REQ-002 Parameter WAIT_CYC, default 2: wait cycles between request accept and response; legal range 1..7.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 clear  input  1  reset; asynchronous and active-low (asserted at 0).
REQ-005 read  input  1  read request strobe from the control unit, level-sampled.
REQ-006 write  input  1  write request strobe from the control unit, level-sampled.
REQ-007 addr  input  9  word address, driven from MAR[8:0].
REQ-008 wdata  input  32  write data, driven from the bus.
REQ-009 rdata  output  32  read data toward MDR; holds its value until the next read response.
REQ-010 done  output  1  one-cycle pulse marking completion of an accepted read or write.
REQ-011 busy  output  1  high from the accept edge until the edge after done.
REQ-012 req_err  output  1  one-cycle pulse on a rejected request.
REQ-013 par_err  output  1  read parity flag; exists only with MEM_PARITY_EN (see Configuration).

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT, RESP.
REQ-015 In IDLE with exactly one of read/write high, the block SHALL capture addr, wdata and the operation, load wait counter = WAIT_CYC, set busy, and go to WAIT.
REQ-016 In IDLE with read and write both high, the block SHALL stay in IDLE and pulse req_err for one cycle; memory is unchanged.
REQ-017 In IDLE with a captured address >= DEPTH, the request SHALL be rejected: req_err pulses, memory is unchanged, and no done is produced.
REQ-018 In WAIT the counter SHALL decrement each cycle; at count 1 the FSM SHALL go to RESP.
REQ-019 In RESP, a read SHALL load rdata from mem[captured addr] and a write SHALL store captured wdata to mem[captured addr].
REQ-020 In RESP, done SHALL pulse and the FSM SHALL return to IDLE; busy SHALL drop on the following edge.
REQ-021 Latency SHALL be WAIT_CYC+1 cycles from the accept edge to the done edge; rdata SHALL be valid in the same cycle as done.
REQ-022 Requests, addr changes and wdata changes while busy SHALL be ignored; the block has no queue.
REQ-023 A request held high through done SHALL be re-accepted in the next IDLE cycle; the controller deasserts read/write upon done.
REQ-024 Back-to-back throughput SHALL be at most one operation per WAIT_CYC+2 cycles.
REQ-025 Read-after-write to the same address SHALL return the newly written data.

Reset
REQ-026 On clear low: FSM = IDLE, rdata = 0, done = 0, busy = 0, req_err = 0, par_err = 0, counter = 0, captured registers = 0.
REQ-027 The memory array SHALL NOT be reset; a write aborted by reset mid-WAIT SHALL leave memory unchanged.
REQ-028 After clear deasserts, the first request SHALL be accepted on the first rising edge.

Configuration
REQ-029 The macro MEM_PARITY_EN SHALL control the parity feature.
REQ-030 With MEM_PARITY_EN defined: each word stores an even-parity bit, computed at write time.
REQ-031 With MEM_PARITY_EN defined: a read whose stored parity mismatches SHALL set par_err together with done; par_err holds until the next read response or reset.
REQ-032 Without MEM_PARITY_EN: there is no parity storage and par_err SHALL be tied to 0.

Verification
REQ-033 Write 0xDEADBEEF to addr 5, then read addr 5 -> done pulses on cycle 3 after each accept (WAIT_CYC=2); rdata = 0xDEADBEEF.
REQ-034 read=1 and write=1 together in IDLE -> req_err pulses 1 cycle, busy stays 0, and a later read of the target address returns the prior contents.
REQ-035 Toggle addr and write during WAIT of a read of addr 3 -> rdata = mem[3], no write occurs, and exactly one done pulse.
REQ-036 Assert clear low for 1 cycle during WAIT of a write of 0x12345678 to addr 9 -> all outputs 0, mem[9] unchanged, and the next read of addr 9 completes normally.
REQ-037 DEPTH=256 and a read of addr 300 -> req_err pulses, no done pulse, rdata unchanged.
REQ-038 MEM_PARITY_EN defined, force a bit flip in stored word 7, then read addr 7 -> par_err = 1 with done; a subsequent clean read clears par_err.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word memory with fixed-latency read/write handshake.
// Optional even-parity storage and read checking is enabled by defining MEM_PARITY_EN.
module mem_responder #(
    parameter int DEPTH    = 512,
    parameter int WAIT_CYC = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        read,
    input  logic        write,
    input  logic [8:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        req_err,
    output logic        par_err
);
    localparam int AW = $clog2(DEPTH);
`ifdef MEM_PARITY_EN
    localparam int MW = 33;
`else
    localparam int MW = 32;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [8:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        req_err_q, req_err_d;
    logic        par_err_q, par_err_d;
    logic        mem_we;
    logic        addr_ok;
    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] word;
    logic [MW-1:0] mem_wdata;

    assign addr_ok = {1'b0, addr} < 10'(DEPTH);
    assign word    = mem[addr_q[AW-1:0]];
`ifdef MEM_PARITY_EN
    assign mem_wdata = {^wdata_q, wdata_q};
`else
    assign mem_wdata = wdata_q;
`endif

    // Next-state and output logic: accept in IDLE, count down in WAIT, complete in RESP
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        req_err_d = 1'b0;
        par_err_d = par_err_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if ((read ^ write) && addr_ok) begin
                    state_d = WAIT;
                    cnt_d   = 3'(WAIT_CYC);
                    addr_d  = addr;
                    wdata_d = wdata;
                    wr_d    = write;
                    busy_d  = 1'b1;
                end else if (read | write) begin
                    req_err_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d   = cnt_q - 3'd1;
                state_d = (cnt_q == 3'd1) ? RESP : WAIT;
            end
            RESP: begin
                state_d = IDLE;
                done_d  = 1'b1;
                mem_we  = wr_q;
                if (!wr_q) begin
                    rdata_d = word[31:0];
`ifdef MEM_PARITY_EN
                    par_err_d = ^word;
`else
                    par_err_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and captured-request registers; clear aborts any pending operation
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            req_err_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            req_err_q <= req_err_d;
            par_err_q <= par_err_d;
        end
    end

    // Storage array is deliberately not reset; writes only land in RESP
    always_ff @(posedge clock) begin
        if (mem_we) mem[addr_q[AW-1:0]] <= mem_wdata;
    end

    assign rdata   = rdata_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign req_err = req_err_q;
    assign par_err = par_err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (DEPTH=256, WAIT_CYC=2).
module tb_mem_responder;
    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        done, busy, req_err, par_err;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic        par;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    mem_responder #(.DEPTH(256), .WAIT_CYC(2)) dut (
        .clock(clock), .clear(clear), .read(read), .write(write), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
        .req_err(req_err), .par_err(par_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (clear && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_busy", 32'(busy), 32'd1);
                if (!e.wr) begin
                    check("rdata", rdata, e.data);
                    check("par_err", 32'(par_err), 32'(e.par));
                end
            end
        end
    end

    task automatic wait_done(input int lat);
        int n;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!done && n < 20);
        read = 1'b0;
        write = 1'b0;
        check("latency", 32'(n), 32'(lat));
        @(posedge clock); #1;
        check("busy_drop", 32'(busy), 32'd0);
        check("done_width", 32'(done), 32'd0);
    endtask

    task automatic op(input logic wr, input logic [8:0] a, input logic [31:0] d, input logic [31:0] exp, input logic ep);
        read = !wr;
        write = wr;
        addr = a;
        wdata = d;
        sb.push_back('{wr, exp, ep});
        @(posedge clock); #1;
        read = 1'b0;
        write = 1'b0;
        addr = ~a;
        wdata = ~d;
        check("busy_accept", 32'(busy), 32'd1);
        wait_done(LAT);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_req_err"}, 32'(req_err), 32'd0);
        check({tag, "_par_err"}, 32'(par_err), 32'd0);
    endtask

    initial begin
        int dc;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        clear = 1'b1;
        op(1'b1, 9'd5, 32'hDEADBEEF, 32'h0, 1'b0);
        op(1'b0, 9'd5, 32'h0, 32'hDEADBEEF, 1'b0);
        op(1'b1, 9'd3, 32'h11111111, 32'h0, 1'b0);
        op(1'b1, 9'd9, 32'hA5A5A5A5, 32'h0, 1'b0);
        op(1'b1, 9'd20, 32'h0BADF00D, 32'h0, 1'b0);
        op(1'b0, 9'd3, 32'h0, 32'h11111111, 1'b0);
        // Conflicting read and write strobes
        read = 1'b1;
        write = 1'b1;
        addr = 9'd20;
        wdata = 32'hFFFFFFFF;
        @(posedge clock); #1;
        read = 1'b0;
        write = 1'b0;
        check("both_req_err", 32'(req_err), 32'd1);
        check("both_busy", 32'(busy), 32'd0);
        @(posedge clock); #1;
        check("both_req_err_pulse", 32'(req_err), 32'd0);
        op(1'b0, 9'd20, 32'h0, 32'h0BADF00D, 1'b0);
        // Inputs toggled during WAIT are ignored
        read = 1'b1;
        addr = 9'd3;
        sb.push_back('{1'b0, 32'h11111111, 1'b0});
        dc = done_cnt;
        @(posedge clock); #1;
        read = 1'b0;
        write = 1'b1;
        addr = 9'd9;
        wdata = 32'hDEAD0000;
        wait_done(LAT);
        check("toggle_one_done", 32'(done_cnt - dc), 32'd1);
        op(1'b0, 9'd9, 32'h0, 32'hA5A5A5A5, 1'b0);
        // Clear asserted mid-WAIT of a write aborts it
        write = 1'b1;
        addr = 9'd9;
        wdata = 32'h12345678;
        @(posedge clock); #1;
        write = 1'b0;
        @(posedge clock); #1;
        clear = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(negedge clock);
        clear = 1'b1;
        op(1'b0, 9'd9, 32'h0, 32'hA5A5A5A5, 1'b0);
        // Out-of-range address
        dc = done_cnt;
        read = 1'b1;
        addr = 9'd300;
        @(posedge clock); #1;
        read = 1'b0;
        check("range_req_err", 32'(req_err), 32'd1);
        check("range_busy", 32'(busy), 32'd0);
        repeat (6) @(posedge clock);
        #1;
        check("range_no_done", 32'(done_cnt - dc), 32'd0);
        check("range_rdata", rdata, 32'hA5A5A5A5);
        // Read-after-write to the same address
        op(1'b1, 9'd20, 32'hCAFEF00D, 32'h0, 1'b0);
        op(1'b0, 9'd20, 32'h0, 32'hCAFEF00D, 1'b0);
        // Request held through done is re-accepted on the next IDLE cycle
        read = 1'b1;
        addr = 9'd5;
        sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        repeat (LAT + 1) @(posedge clock);
        #1;
        check("held_done1", 32'(done), 32'd1);
        @(posedge clock); #1;
        check("held_reaccept_busy", 32'(busy), 32'd1);
        check("held_reaccept_done", 32'(done), 32'd0);
        read = 1'b0;
        wait_done(LAT);
`ifdef MEM_PARITY_EN
        op(1'b1, 9'd7, 32'h00000000, 32'h0, 1'b0);
        dut.mem[7][0] = ~dut.mem[7][0];
        op(1'b0, 9'd7, 32'h0, 32'h00000001, 1'b1);
        check("par_hold", 32'(par_err), 32'd1);
        op(1'b0, 9'd5, 32'h0, 32'hDEADBEEF, 1'b0);
`endif
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
